i2c_byte_fifo: RTL and testbench

//  Byte buffer between the host/register bank and the I2C master engine.
//  TX side: the host queues the bytes to write. The block presents them to the master as a

---
 rtl/i2c_byte_fifo.sv | 147 ++++++++++++++
 tb/tb_i2c_byte_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/i2c_byte_fifo.sv
// Byte buffering between the host register bank and the I2C master engine.
// It holds one show-ahead TX queue, one RX queue, sticky error flags and a synchronous flush.

module i2c_byte_fifo_core #(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               push_i,
    input  logic [7:0]         data_i,
    input  logic               pop_i,
    output logic [7:0]         data_o,
    output logic [LEVEL_W-1:0] level_o,
    output logic               overflow_o,
    output logic               underflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               full, empty, push_ok, pop_ok;

    assign full    = (level_q == LEVEL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign pop_ok  = pop_i & ~empty;
    // A pop in the same cycle makes room, so a full FIFO still accepts the push.
    assign push_ok = push_i & (~full | pop_ok);

    assign overflow_o  = push_i & ~push_ok;
    assign underflow_o = pop_i & empty;
    assign level_o     = level_q;
    assign data_o      = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_ok & ~pop_ok)      level_d = level_q + 1'b1;
            else if (pop_ok & ~push_ok) level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset; the empty check masks stale contents on data_o.
    always_ff @(posedge clock_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

module i2c_byte_fifo #(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               flush_i,
    input  logic               tx_push_i,
    input  logic [7:0]         tx_data_i,
    output logic               tx_full_o,
    output logic [LEVEL_W-1:0] tx_level_o,
    output logic               data_available_o,
    output logic [7:0]         data_o,
    input  logic               data_read_i,
    input  logic               rx_valid_i,
    input  logic [7:0]         rx_data_i,
    input  logic               rx_pop_i,
    output logic [7:0]         rx_data_o,
    output logic               rx_empty_o,
    output logic [LEVEL_W-1:0] rx_level_o,
    output logic               overflow_o,
    output logic               underflow_o
);
    logic tx_ovf, tx_unf, rx_ovf, rx_unf;
    logic ovf_q, ovf_d, unf_q, unf_d;

    i2c_byte_fifo_core #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) u_tx (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .flush_i     (flush_i),
        .push_i      (tx_push_i),
        .data_i      (tx_data_i),
        .pop_i       (data_read_i),
        .data_o      (data_o),
        .level_o     (tx_level_o),
        .overflow_o  (tx_ovf),
        .underflow_o (tx_unf)
    );

    i2c_byte_fifo_core #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) u_rx (
        .clock_i     (clock_i),
        .reset_n_i   (reset_n_i),
        .flush_i     (flush_i),
        .push_i      (rx_valid_i),
        .data_i      (rx_data_i),
        .pop_i       (rx_pop_i),
        .data_o      (rx_data_o),
        .level_o     (rx_level_o),
        .overflow_o  (rx_ovf),
        .underflow_o (rx_unf)
    );

    assign tx_full_o        = (tx_level_o == LEVEL_W'(DEPTH));
    assign data_available_o = (tx_level_o != '0);
    assign rx_empty_o       = (rx_level_o == '0);
    assign overflow_o       = ovf_q;
    assign underflow_o      = unf_q;

    always_comb begin
        ovf_d = ovf_q | tx_ovf | rx_ovf;
        unf_d = unf_q | tx_unf | rx_unf;
        if (flush_i) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
endmodule

// File: tb/tb_i2c_byte_fifo.sv
// Self-checking bench for i2c_byte_fifo: directed scenarios plus random traffic against a queue model.
module tb_i2c_byte_fifo;
    localparam int DEPTH   = 16;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic               clock_i = 1'b0;
    logic               reset_n_i = 1'b0;
    logic               flush_i = 1'b0, tx_push_i = 1'b0, data_read_i = 1'b0;
    logic               rx_valid_i = 1'b0, rx_pop_i = 1'b0;
    logic [7:0]         tx_data_i = 8'h00, rx_data_i = 8'h00;
    logic               tx_full_o, data_available_o, rx_empty_o, overflow_o, underflow_o;
    logic [LEVEL_W-1:0] tx_level_o, rx_level_o;
    logic [7:0]         data_o, rx_data_o;

    i2c_byte_fifo #(.DEPTH(DEPTH), .LEVEL_W(LEVEL_W)) dut (
        .clock_i          (clock_i),
        .reset_n_i        (reset_n_i),
        .flush_i          (flush_i),
        .tx_push_i        (tx_push_i),
        .tx_data_i        (tx_data_i),
        .tx_full_o        (tx_full_o),
        .tx_level_o       (tx_level_o),
        .data_available_o (data_available_o),
        .data_o           (data_o),
        .data_read_i      (data_read_i),
        .rx_valid_i       (rx_valid_i),
        .rx_data_i        (rx_data_i),
        .rx_pop_i         (rx_pop_i),
        .rx_data_o        (rx_data_o),
        .rx_empty_o       (rx_empty_o),
        .rx_level_o       (rx_level_o),
        .overflow_o       (overflow_o),
        .underflow_o      (underflow_o)
    );

    always #5 clock_i = ~clock_i;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    bit          m_ovf = 0, m_unf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("tx_level",  32'(tx_level_o), 32'(txq.size()));
        chk("tx_full",   32'(tx_full_o), 32'(txq.size() == DEPTH));
        chk("data_avail",32'(data_available_o), 32'(txq.size() != 0));
        chk("data_o",    32'(data_o), (txq.size() != 0) ? 32'(txq[0]) : 32'h0);
        chk("rx_level",  32'(rx_level_o), 32'(rxq.size()));
        chk("rx_empty",  32'(rx_empty_o), 32'(rxq.size() == 0));
        chk("rx_data_o", 32'(rx_data_o), (rxq.size() != 0) ? 32'(rxq[0]) : 32'h0);
        chk("overflow",  32'(overflow_o), 32'(m_ovf));
        chk("underflow", 32'(underflow_o), 32'(m_unf));
    endtask

    // Drive one cycle of inputs (called at a falling edge), update the model at the
    // rising edge, then compare at the next falling edge.
    task automatic cyc(input bit fl, input bit tp, input logic [7:0] td, input bit rd,
                       input bit rv, input logic [7:0] rdd, input bit rp);
        bit tx_pop_ok, tx_push_ok, rx_pop_ok, rx_push_ok;
        flush_i = fl; tx_push_i = tp; tx_data_i = td; data_read_i = rd;
        rx_valid_i = rv; rx_data_i = rdd; rx_pop_i = rp;
        @(posedge clock_i);
        if (fl) begin
            txq.delete(); rxq.delete(); m_ovf = 0; m_unf = 0;
        end else begin
            tx_pop_ok  = rd && txq.size() > 0;
            tx_push_ok = tp && (txq.size() < DEPTH || tx_pop_ok);
            rx_pop_ok  = rp && rxq.size() > 0;
            rx_push_ok = rv && (rxq.size() < DEPTH || rx_pop_ok);
            if ((rd && !tx_pop_ok) || (rp && !rx_pop_ok)) m_unf = 1;
            if ((tp && !tx_push_ok) || (rv && !rx_push_ok)) m_ovf = 1;
            if (tx_pop_ok)  void'(txq.pop_front());
            if (tx_push_ok) txq.push_back(td);
            if (rx_pop_ok)  void'(rxq.pop_front());
            if (rx_push_ok) rxq.push_back(rdd);
        end
        @(negedge clock_i);
        flush_i = 0; tx_push_i = 0; data_read_i = 0; rx_valid_i = 0; rx_pop_i = 0;
        check_all();
    endtask

    initial begin
        #12;
        check_all();                       // values held in reset
        @(negedge clock_i);
        reset_n_i = 1'b1;
        @(negedge clock_i);
        check_all();

        // TX show-ahead and master pops
        cyc(0, 1, 8'hA5, 0, 0, 0, 0);
        chk("first_avail", 32'(data_available_o), 32'h1);
        chk("first_head",  32'(data_o), 32'hA5);
        cyc(0, 1, 8'h3C, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("second_head", 32'(data_o), 32'h3C);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("tx_drained", 32'(data_available_o), 32'h0);

        // DEPTH+1 pushes: last one dropped, then drain in order
        for (int i = 0; i <= DEPTH; i++) cyc(0, 1, 8'(8'h40 + i), 0, 0, 0, 0);
        chk("full_after_depth", 32'(tx_full_o), 32'h1);
        chk("ovf_on_extra",     32'(overflow_o), 32'h1);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // RX strobes then pops, one extra pop underflows
        for (int i = 1; i <= 3; i++) cyc(0, 0, 0, 0, 1, 8'(i), 0);
        chk("rx_head_01", 32'(rx_data_o), 32'h01);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        chk("rx_empty_after", 32'(rx_empty_o), 32'h1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("unf_rx_pop", 32'(underflow_o), 32'h1);

        // Flush clears flags so the later checks start clean
        cyc(1, 0, 0, 0, 0, 0, 0);

        // Steady push+pop at DEPTH-1 for 2*DEPTH cycles
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 1, 8'(8'h80 + i), 0, 0, 0, 0);
        for (int i = 0; i < 2 * DEPTH; i++) cyc(0, 1, 8'($urandom), 1, 0, 0, 0);
        chk("steady_level", 32'(tx_level_o), 32'(DEPTH - 1));
        for (int i = 0; i < DEPTH - 1; i++) cyc(0, 0, 0, 1, 0, 0, 0);

        // Push+pop on an empty FIFO
        cyc(0, 1, 8'h5A, 1, 1, 8'hC3, 1);
        chk("empty_pp_level", 32'(tx_level_o), 32'h1);
        chk("empty_pp_unf",   32'(underflow_o), 32'h1);
        chk("empty_pp_head",  32'(data_o), 32'h5A);

        // Push+pop on a full FIFO: no overflow
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 8'(i), 0, 0, 0, 0);
        cyc(0, 1, 8'hEE, 1, 0, 0, 0);
        chk("full_pp_ovf", 32'(overflow_o), 32'h0);

        // Three bytes each side with overflow set, flush together with a push
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'(8'h10 + i), 0, 1, 8'(8'h20 + i), 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, 8'(i), 0);
        chk("pre_flush_ovf", 32'(overflow_o), 32'h1);
        cyc(1, 1, 8'h99, 0, 1, 8'h77, 0);
        chk("flush_tx_level", 32'(tx_level_o), 32'h0);
        chk("flush_ovf", 32'(overflow_o), 32'h0);

        // Random traffic: push-heavy phase then pop-heavy phase, rare flushes
        for (int i = 0; i < 400; i++) begin
            int pp;
            pp = (i < 200) ? 70 : 30;
            cyc($urandom_range(0, 59) == 0,
                $urandom_range(0, 99) < pp, 8'($urandom),
                $urandom_range(0, 99) < (100 - pp),
                $urandom_range(0, 99) < pp, 8'($urandom),
                $urandom_range(0, 99) < (100 - pp));
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) cyc(0, 1, 8'(8'hB0 + i), 0, 1, 8'(i), 0);
        cyc(0, 1, 8'hFF, 0, 0, 0, 1);
        #2 reset_n_i = 1'b0;
        #1;
        txq.delete(); rxq.delete(); m_ovf = 0; m_unf = 0;
        check_all();
        @(negedge clock_i);
        reset_n_i = 1'b1;
        cyc(0, 1, 8'h6E, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
